// File: rtl/cpu7_ifu_fcl.sv
// Fetch control for the IFU PC datapath.
// Issues instruction requests under an outstanding/queue credit limit.
// Drives the active-low one-hot pc_bf mux selects.
// Drops stale returns after a redirect.
// Buffers returned instructions for decode port0.
module cpu7_ifu_fcl #(
  parameter int MAX_OUTST = 2,
  parameter int IQ_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_addr,
  output logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_valid,
  input  logic [31:0] inst_rdata,
  input  logic        inst_ex,
  input  logic [5:0]  inst_exccode,
  output logic        inst_cancel,
  input  logic        br_cancel,
  output logic        pcbf_sel_init_l,
  output logic        pcbf_sel_old_l,
  output logic        pcbf_sel_inc_l,
  output logic        pcbf_sel_br_l,
  input  logic        o_allow0,
  output logic        o_valid0,
  output logic [31:0] o_port0_pc,
  output logic [31:0] o_port0_inst,
  output logic        o_port0_ex,
  output logic [5:0]  o_port0_exccode
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int IW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  // iq entry layout: {pc[31:0], inst[31:0], ex, exccode[5:0]}
  localparam int EW = 71;

  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] iq_cnt_q, iq_cnt_d;
  logic [IW-1:0] iq_wp_q, iq_wp_d;
  logic [IW-1:0] iq_rp_q, iq_rp_d;
  logic [PW-1:0] pq_wp_q, pq_wp_d;
  logic [PW-1:0] pq_rp_q, pq_rp_d;

  logic [31:0]   pq_mem_q [MAX_OUTST];
  logic [EW-1:0] iq_mem_q [IQ_DEPTH];

  logic          acc;
  logic          ret;
  logic          iq_push;
  logic          iq_pop;
  logic [CW:0]   credit_sum;
  logic [31:0]   ret_pc;
  logic [EW-1:0] head;

  function automatic logic [IW-1:0] iq_next(input logic [IW-1:0] p);
    return (p == IW'(IQ_DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  function automatic logic [PW-1:0] pq_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit rule: never more fetches in flight than the iq can still absorb.
  assign credit_sum = (CW+1)'(outst_q) + (CW+1)'(iq_cnt_q);
  assign inst_req   = reset & ~br_cancel & (outst_q < OW'(MAX_OUTST))
                    & (credit_sum < (CW+1)'(IQ_DEPTH));
  assign acc        = inst_req & inst_addr_ok;
  // A return with nothing tracked (e.g. from before a reset) is ignored.
  assign ret        = inst_valid & (outst_q != '0);
  assign iq_push    = ret & ~br_cancel & (drop_q == '0);
  assign ret_pc     = pq_mem_q[pq_rp_q];
  assign inst_cancel = br_cancel;

  // One-hot low selects, priority init > br > inc > old.
  assign pcbf_sel_init_l = reset;
  assign pcbf_sel_br_l   = ~(reset & br_cancel);
  assign pcbf_sel_inc_l  = ~(reset & ~br_cancel & acc_q);
  assign pcbf_sel_old_l  = ~(reset & ~br_cancel & ~acc_q);

  assign o_valid0 = (iq_cnt_q != '0);
  assign iq_pop   = o_valid0 & o_allow0;
  assign head     = iq_mem_q[iq_rp_q];

  assign o_port0_pc      = o_valid0 ? head[70:39] : '0;
  assign o_port0_inst    = o_valid0 ? head[38:7]  : '0;
  assign o_port0_ex      = o_valid0 ? head[6]     : 1'b0;
  assign o_port0_exccode = o_valid0 ? head[5:0]   : '0;

  // Next-state for counters, pointers and the drop counter.
  always_comb begin
    outst_d  = outst_q;
    drop_d   = drop_q;
    acc_d    = acc;
    iq_cnt_d = iq_cnt_q;
    iq_wp_d  = iq_wp_q;
    iq_rp_d  = iq_rp_q;
    pq_wp_d  = pq_wp_q;
    pq_rp_d  = pq_rp_q;

    if (acc && !ret) begin
      outst_d = outst_q + OW'(1);
    end else if (!acc && ret) begin
      outst_d = outst_q - OW'(1);
    end

    if (acc) pq_wp_d = pq_next(pq_wp_q);
    if (ret) pq_rp_d = pq_next(pq_rp_q);

    // On redirect every fetch still in flight after this cycle is stale.
    if (br_cancel) begin
      drop_d = outst_q - OW'(ret);
    end else if (ret && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end

    if (br_cancel) begin
      iq_cnt_d = '0;
      iq_rp_d  = iq_wp_q;
    end else begin
      if (iq_push) iq_wp_d = iq_next(iq_wp_q);
      if (iq_pop)  iq_rp_d = iq_next(iq_rp_q);
      if (iq_push && !iq_pop) begin
        iq_cnt_d = iq_cnt_q + CW'(1);
      end else if (!iq_push && iq_pop) begin
        iq_cnt_d = iq_cnt_q - CW'(1);
      end
    end
  end

  // Control state, cleared by synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      outst_q  <= '0;
      drop_q   <= '0;
      acc_q    <= 1'b0;
      iq_cnt_q <= '0;
      iq_wp_q  <= '0;
      iq_rp_q  <= '0;
      pq_wp_q  <= '0;
      pq_rp_q  <= '0;
    end else begin
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      acc_q    <= acc_d;
      iq_cnt_q <= iq_cnt_d;
      iq_wp_q  <= iq_wp_d;
      iq_rp_q  <= iq_rp_d;
      pq_wp_q  <= pq_wp_d;
      pq_rp_q  <= pq_rp_d;
    end
  end

  // Storage for request pcs and queued instructions; validity lives in the counters.
  always_ff @(posedge clock) begin
    if (acc) begin
      pq_mem_q[pq_wp_q] <= inst_addr;
    end
    if (iq_push) begin
      iq_mem_q[iq_wp_q] <= {ret_pc, inst_rdata, inst_ex, inst_exccode};
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Bench for cpu7_ifu_fcl: a small PC datapath and in-order memory around the
// DUT, with a queue-based reference model checked every cycle.
module tb_cpu7_ifu_fcl;

  localparam int MAXO = 2;
  localparam int IQD  = 4;
  localparam logic [31:0] PC_INIT = 32'h1c00_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_addr;
  logic        inst_req;
  logic        inst_addr_ok;
  logic        inst_valid;
  logic [31:0] inst_rdata;
  logic        inst_ex;
  logic [5:0]  inst_exccode;
  logic        inst_cancel;
  logic        br_cancel;
  logic        pcbf_sel_init_l, pcbf_sel_old_l, pcbf_sel_inc_l, pcbf_sel_br_l;
  logic        o_allow0;
  logic        o_valid0;
  logic [31:0] o_port0_pc;
  logic [31:0] o_port0_inst;
  logic        o_port0_ex;
  logic [5:0]  o_port0_exccode;

  always #5 clock = ~clock;

  cpu7_ifu_fcl #(.MAX_OUTST(MAXO), .IQ_DEPTH(IQD)) dut (
    .clock(clock), .reset(reset), .inst_addr(inst_addr), .inst_req(inst_req),
    .inst_addr_ok(inst_addr_ok), .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .inst_ex(inst_ex), .inst_exccode(inst_exccode), .inst_cancel(inst_cancel),
    .br_cancel(br_cancel), .pcbf_sel_init_l(pcbf_sel_init_l),
    .pcbf_sel_old_l(pcbf_sel_old_l), .pcbf_sel_inc_l(pcbf_sel_inc_l),
    .pcbf_sel_br_l(pcbf_sel_br_l), .o_allow0(o_allow0), .o_valid0(o_valid0),
    .o_port0_pc(o_port0_pc), .o_port0_inst(o_port0_inst), .o_port0_ex(o_port0_ex),
    .o_port0_exccode(o_port0_exccode)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } ent_t;

  // reference model
  ent_t        m_iq[$];
  logic [31:0] m_pcq[$];
  int          m_outst = 0;
  int          m_drop  = 0;
  bit          m_accp  = 0;
  bit          m_known = 0;
  bit          m_zero  = 0;

  // memory side
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          lat_min = 1, lat_max = 1;
  int          p_ok = 100, p_ret = 100;
  bit          force_ex = 0;

  // datapath
  logic [31:0] pc_f = PC_INIT;
  logic [31:0] br_tgt = 32'h1c00_0100;
  logic [31:0] pc_bf_v;

  bit          track_seq = 0;
  logic [31:0] seq_next;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance the model, cross posedge.
  task automatic step(input bit rn, input bit br, input bit allow, input bit stray);
    bit   have, exp_req, acc, ret, popq;
    ent_t e;
    logic [31:0] rpc;
    rpc = '0;
    reset = rn;
    br_cancel = br;
    o_allow0 = allow;
    have = (mem_addr.size() != 0) && (mem_due[0] <= cyc) && ($urandom_range(99) < p_ret);
    if (have || stray) begin
      inst_valid   = 1'b1;
      inst_rdata   = have ? rdata_of(mem_addr[0]) : $urandom;
      inst_ex      = (have && force_ex) ? 1'b1 : ($urandom_range(7) == 0);
      inst_exccode = (have && force_ex) ? 6'h08 : 6'($urandom);
      if (have) force_ex = 0;
    end else begin
      inst_valid   = 1'b0;
      inst_rdata   = $urandom;
      inst_ex      = 1'($urandom_range(1));
      inst_exccode = 6'($urandom);
    end
    inst_addr_ok = ($urandom_range(99) < p_ok);
    #1;
    if (!pcbf_sel_init_l)     pc_bf_v = PC_INIT;
    else if (!pcbf_sel_br_l)  pc_bf_v = br_tgt;
    else if (!pcbf_sel_inc_l) pc_bf_v = pc_f + 32'd4;
    else                      pc_bf_v = pc_f;
    inst_addr = pc_bf_v;
    #1;
    exp_req = rn && !br && (m_outst < MAXO) && ((m_outst + m_iq.size()) < IQD);
    chk("inst_req", inst_req, exp_req);
    chk("inst_cancel", inst_cancel, br);
    chk("sel_init_l", pcbf_sel_init_l, rn);
    chk("sel_br_l", pcbf_sel_br_l, !(rn && br));
    chk("sel_inc_l", pcbf_sel_inc_l, !(rn && !br && m_accp));
    chk("sel_old_l", pcbf_sel_old_l, !(rn && !br && !m_accp));
    if (m_known) begin
      chk("o_valid0", o_valid0, m_iq.size() != 0);
      if (m_iq.size() != 0) begin
        e = m_iq[0];
        chk("port0_pc", o_port0_pc, e.pc);
        chk("port0_inst", o_port0_inst, e.inst);
        chk("port0_ex", o_port0_ex, e.ex);
        chk("port0_exccode", o_port0_exccode, e.code);
        if (track_seq && allow) begin
          chk("seq_pc", o_port0_pc, seq_next);
          seq_next = seq_next + 32'd4;
        end
      end else if (m_zero) begin
        chk("reset_port0", {o_port0_pc, o_port0_ex, o_port0_exccode}, 39'd0);
        chk("reset_inst", o_port0_inst, 32'd0);
      end
    end
    acc  = exp_req && inst_addr_ok;
    ret  = inst_valid && (m_outst > 0);
    popq = (m_iq.size() != 0) && allow;
    if (have) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (acc) begin
      mem_addr.push_back(inst_addr);
      mem_due.push_back(cyc + $urandom_range(lat_max, lat_min));
    end
    if (!rn) begin
      m_iq.delete(); m_pcq.delete(); mem_addr.delete(); mem_due.delete();
      m_outst = 0; m_drop = 0; m_accp = 0; m_known = 1; m_zero = 1;
    end else begin
      if (ret) begin rpc = m_pcq.pop_front(); m_outst--; end
      if (acc) begin m_pcq.push_back(inst_addr); m_outst++; end
      if (br) begin
        m_iq.delete();
        m_drop = m_outst;
      end else begin
        if (popq) void'(m_iq.pop_front());
        if (ret) begin
          if (m_drop > 0) m_drop--;
          else begin
            e.pc = rpc; e.inst = inst_rdata; e.ex = inst_ex; e.code = inst_exccode;
            m_iq.push_back(e);
            m_zero = 0;
          end
        end
      end
      m_accp = acc;
    end
    @(posedge clock);
    pc_f = pc_bf_v;
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    bit ok;
    reset = 1'b0; br_cancel = 1'b0; o_allow0 = 1'b1; inst_valid = 1'b0;
    inst_addr_ok = 1'b0; inst_addr = '0; inst_rdata = '0; inst_ex = 1'b0; inst_exccode = '0;
    @(negedge clock);

    // Reset, with a stray return in the last reset cycle.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);

    // Streaming: accept every cycle, return one cycle later, decode always ready.
    track_seq = 1; seq_next = PC_INIT;
    lat_min = 1; lat_max = 1; p_ok = 100; p_ret = 100;
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0);

    // Decode stalls: iq fills, requests stop, nothing lost.
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    #2;
    chk("req_when_full", inst_req, 1'b0);
    chk("valid_when_full", o_valid0, 1'b1);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0);

    // Redirect with two fetches in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && m_outst != MAXO; i++) step(1, 0, 1, 0);
    chk("wait_outst2", m_outst, MAXO);
    br_tgt = 32'h1c00_0100;
    step(1, 1, 1, 0);
    seq_next = 32'h1c00_0100;
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0);

    // Exception on a return.
    force_ex = 1;
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0);

    // Reset mid-flight with fetches outstanding and the iq occupied.
    track_seq = 0; lat_min = 2; lat_max = 2;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step(1, 0, 0, 0);
      ok = (m_outst >= 1) && (m_iq.size() >= 2);
    end
    chk("wait_busy", ok, 1'b1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);

    // Random traffic with redirects and occasional resets.
    lat_min = 1; lat_max = 4; p_ok = 70; p_ret = 70;
    for (int i = 0; i < 800; i++) begin
      bit rn, br;
      rn = ($urandom_range(99) != 0);
      br = rn && ($urandom_range(99) < 4);
      if (br) br_tgt = {4'h1, 26'($urandom), 2'b00};
      step(rn, br, ($urandom_range(99) < 70), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
